ctrl_pipe: RTL and testbench

//  Consumer end of the main-decoder control interface: registers decode-stage control

---
 rtl/ctrl_pipe_pkg.sv | 23 ++
 rtl/ctrl_pipe_if.sv | 61 ++++++
 rtl/ctrl_stage_reg.sv | 23 ++
 rtl/ctrl_pipe.sv | 123 ++++++++++++
 tb/tb_ctrl_pipe.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the E/M/W control pipeline: control payload, forward selects.
package ctrl_pipe_pkg;

  // Decode-stage control bits carried into E
  typedef struct packed {
    logic       reg_write;
    logic       result_src;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_e_t;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // ResultSrc value meaning "result comes from load data"
  localparam logic RESULT_MEM = 1'b1;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle between decoder/datapath and the control pipeline.
interface ctrl_pipe_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) ();

  // D-stage inputs from maindec / regfile
  logic              valid_d;
  logic              reg_write_d;
  logic              alu_src_d;
  logic              mem_write_d;
  logic              result_src_d;
  logic [1:0]        alu_op_d;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;

  // E-stage inputs held by the datapath
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic              flush_e;

  // Per-stage controls
  logic              alu_src_e;
  logic [1:0]        alu_op_e;
  logic              mem_write_e;
  logic              result_src_e;
  logic              reg_write_e;
  logic              mem_write_m;
  logic              result_src_m;
  logic              reg_write_m;
  logic              result_src_w;
  logic              reg_write_w;
  logic [REG_AW-1:0] rd_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              valid_w;

  // Hazard, forwarding and retire count
  logic              stall_d;
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic [CNT_W-1:0]  retired;

  modport slave (
    input  valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d, alu_op_d,
           rs1_d, rs2_d, rd_d, rs1_e, rs2_e, flush_e,
    output alu_src_e, alu_op_e, mem_write_e, result_src_e, reg_write_e,
           mem_write_m, result_src_m, reg_write_m, result_src_w, reg_write_w,
           rd_e, rd_m, rd_w, valid_w, stall_d, fwd_a_e, fwd_b_e, retired
  );

  modport master (
    output valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d, alu_op_d,
           rs1_d, rs2_d, rd_d, rs1_e, rs2_e, flush_e,
    input  alu_src_e, alu_op_e, mem_write_e, result_src_e, reg_write_e,
           mem_write_m, result_src_m, reg_write_m, result_src_w, reg_write_w,
           rd_e, rd_m, rd_w, valid_w, stall_d, fwd_a_e, fwd_b_e, retired
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// Pipeline stage register with async reset and synchronous clear (bubble insert).
module ctrl_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load next stage contents, or a bubble when cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline D->E->M->W with load-use stall, E-stage forwarding, retire counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave bus
);

  localparam int unsigned CTRL_W = $bits(ctrl_e_t);
  localparam int unsigned E_W    = 1 + REG_AW + CTRL_W;
  localparam int unsigned M_W    = 1 + REG_AW + 3;
  localparam int unsigned W_W    = 1 + REG_AW + 2;

  ctrl_e_t           ctrlD;
  ctrl_e_t           ctrlE;
  logic [E_W-1:0]    eD;
  logic [E_W-1:0]    eQ;
  logic [M_W-1:0]    mD;
  logic [M_W-1:0]    mQ;
  logic [W_W-1:0]    wD;
  logic [W_W-1:0]    wQ;
  logic              validE;
  logic              validM;
  logic              validW;
  logic [REG_AW-1:0] rdE;
  logic [REG_AW-1:0] rdM;
  logic [REG_AW-1:0] rdW;
  logic              regWriteM;
  logic              resultSrcM;
  logic              memWriteM;
  logic              regWriteW;
  logic              resultSrcW;
  logic              stallD;
  logic              clrE;
  fwd_sel_t          fwdA;
  fwd_sel_t          fwdB;
  logic [CNT_W-1:0]  retiredQ;

  assign ctrlD = '{reg_write:  bus.reg_write_d,
                   result_src: bus.result_src_d,
                   mem_write:  bus.mem_write_d,
                   alu_src:    bus.alu_src_d,
                   alu_op:     bus.alu_op_d};

  // Load-use hazard: load in E whose destination is read by the instruction in D
  assign stallD = validE & (ctrlE.result_src == RESULT_MEM) & ctrlE.reg_write &
                  (rdE != '0) & ((rdE == bus.rs1_d) | (rdE == bus.rs2_d));

  // Squash, stall or an empty D slot all enter E as a bubble
  assign clrE = bus.flush_e | stallD | ~bus.valid_d;
  assign eD   = {bus.valid_d, bus.rd_d, ctrlD};

  ctrl_stage_reg #(.W(E_W)) uStageE (
    .clk(clk), .rst_n(rst_n), .clr(clrE), .d(eD), .q(eQ)
  );

  assign {validE, rdE, ctrlE} = eQ;
  assign mD = {validE, rdE, ctrlE.reg_write, ctrlE.result_src, ctrlE.mem_write};

  ctrl_stage_reg #(.W(M_W)) uStageM (
    .clk(clk), .rst_n(rst_n), .clr(~validE), .d(mD), .q(mQ)
  );

  assign {validM, rdM, regWriteM, resultSrcM, memWriteM} = mQ;
  assign wD = {validM, rdM, regWriteM, resultSrcM};

  ctrl_stage_reg #(.W(W_W)) uStageW (
    .clk(clk), .rst_n(rst_n), .clr(~validM), .d(wD), .q(wQ)
  );

  assign {validW, rdW, regWriteW, resultSrcW} = wQ;

  // Operand source for one E-stage register; M result is newer than W
  function automatic fwd_sel_t fwdSel(input logic [REG_AW-1:0] rs);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (validM && regWriteM && (rdM != '0) && (rdM == rs)) begin
      sel = FWD_M;
    end else if (validW && regWriteW && (rdW != '0) && (rdW == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Forwarding selects for both E-stage operands
  always_comb begin
    fwdA = fwdSel(bus.rs1_e);
    fwdB = fwdSel(bus.rs2_e);
  end

  // Count instructions leaving W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredQ <= '0;
    end else if (validW) begin
      retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  assign bus.alu_src_e    = ctrlE.alu_src;
  assign bus.alu_op_e     = ctrlE.alu_op;
  assign bus.mem_write_e  = ctrlE.mem_write;
  assign bus.result_src_e = ctrlE.result_src;
  assign bus.reg_write_e  = ctrlE.reg_write;
  assign bus.rd_e         = rdE;
  assign bus.mem_write_m  = memWriteM;
  assign bus.result_src_m = resultSrcM;
  assign bus.reg_write_m  = regWriteM;
  assign bus.rd_m         = rdM;
  assign bus.result_src_w = resultSrcW;
  assign bus.reg_write_w  = regWriteW;
  assign bus.rd_w         = rdW;
  assign bus.valid_w      = validW;
  assign bus.stall_d      = stallD;
  assign bus.fwd_a_e      = 2'(fwdA);
  assign bus.fwd_b_e      = 2'(fwdB);
  assign bus.retired      = retiredQ;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard cases plus random traffic against an
// instruction-level model of the three in-flight slots.
module tb_ctrl_pipe;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       rs;
    logic       mw;
    logic       as;
    logic [1:0] op;
    logic [4:0] rd;
    logic [4:0] r1;
    logic [4:0] r2;
  } ins_t;

  localparam ins_t NOP = '0;

  logic clk;
  logic rst_n;

  ctrl_pipe_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  ctrl_pipe #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned     nTests = 0;
  int unsigned     nFail  = 0;
  ins_t            mE, mM, mW;
  logic [CNT_W-1:0] expRet;
  logic            capStall;
  logic [1:0]      capFwdA;
  logic [1:0]      capFwdB;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic rw, input logic rs,
                              input logic mw, input logic as, input logic [1:0] op,
                              input logic [4:0] rd, input logic [4:0] r1,
                              input logic [4:0] r2);
    ins_t t;
    t.v = v; t.rw = rw; t.rs = rs; t.mw = mw; t.as = as;
    t.op = op; t.rd = rd; t.r1 = r1; t.r2 = r2;
    return t;
  endfunction

  // Which stage should supply register rs to the instruction in E
  function automatic logic [1:0] fwdExp(input logic [4:0] rs);
    if (mM.v && mM.rw && mM.rd != 0 && mM.rd == rs) return 2'b10;
    if (mW.v && mW.rw && mW.rd != 0 && mW.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset();
    mE = NOP; mM = NOP; mW = NOP; expRet = '0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_alu_src_e"}, 32'(bus.alu_src_e), 0);
    chk({tag, "_alu_op_e"}, 32'(bus.alu_op_e), 0);
    chk({tag, "_mem_write_e"}, 32'(bus.mem_write_e), 0);
    chk({tag, "_result_src_e"}, 32'(bus.result_src_e), 0);
    chk({tag, "_reg_write_e"}, 32'(bus.reg_write_e), 0);
    chk({tag, "_rd_e"}, 32'(bus.rd_e), 0);
    chk({tag, "_mem_write_m"}, 32'(bus.mem_write_m), 0);
    chk({tag, "_reg_write_m"}, 32'(bus.reg_write_m), 0);
    chk({tag, "_rd_m"}, 32'(bus.rd_m), 0);
    chk({tag, "_reg_write_w"}, 32'(bus.reg_write_w), 0);
    chk({tag, "_rd_w"}, 32'(bus.rd_w), 0);
    chk({tag, "_valid_w"}, 32'(bus.valid_w), 0);
    chk({tag, "_stall_d"}, 32'(bus.stall_d), 0);
    chk({tag, "_fwd"}, 32'({bus.fwd_a_e, bus.fwd_b_e}), 0);
    chk({tag, "_retired"}, 32'(bus.retired), 0);
  endtask

  task automatic checkRegs();
    chk("alu_src_e", 32'(bus.alu_src_e), 32'(mE.as));
    chk("alu_op_e", 32'(bus.alu_op_e), 32'(mE.op));
    chk("mem_write_e", 32'(bus.mem_write_e), 32'(mE.mw));
    chk("result_src_e", 32'(bus.result_src_e), 32'(mE.rs));
    chk("reg_write_e", 32'(bus.reg_write_e), 32'(mE.rw));
    chk("rd_e", 32'(bus.rd_e), 32'(mE.rd));
    chk("mem_write_m", 32'(bus.mem_write_m), 32'(mM.mw));
    chk("result_src_m", 32'(bus.result_src_m), 32'(mM.rs));
    chk("reg_write_m", 32'(bus.reg_write_m), 32'(mM.rw));
    chk("rd_m", 32'(bus.rd_m), 32'(mM.rd));
    chk("result_src_w", 32'(bus.result_src_w), 32'(mW.rs));
    chk("reg_write_w", 32'(bus.reg_write_w), 32'(mW.rw));
    chk("rd_w", 32'(bus.rd_w), 32'(mW.rd));
    chk("valid_w", 32'(bus.valid_w), 32'(mW.v));
    chk("retired", 32'(bus.retired), 32'(expRet));
  endtask

  // One clock: present d in D (entered at negedge), check hazards, advance model
  task automatic step(input ins_t d, input logic fl, output logic expStall);
    bus.valid_d      = d.v;
    bus.reg_write_d  = d.rw;
    bus.result_src_d = d.rs;
    bus.mem_write_d  = d.mw;
    bus.alu_src_d    = d.as;
    bus.alu_op_d     = d.op;
    bus.rd_d         = d.rd;
    bus.rs1_d        = d.r1;
    bus.rs2_d        = d.r2;
    bus.flush_e      = fl;
    bus.rs1_e        = mE.r1;
    bus.rs2_e        = mE.r2;
    #1;
    expStall = mE.v && mE.rs && mE.rw && mE.rd != 0 && (mE.rd == d.r1 || mE.rd == d.r2);
    chk("stall_d", 32'(bus.stall_d), 32'(expStall));
    chk("fwd_a_e", 32'(bus.fwd_a_e), 32'(fwdExp(mE.r1)));
    chk("fwd_b_e", 32'(bus.fwd_b_e), 32'(fwdExp(mE.r2)));
    capStall = bus.stall_d;
    capFwdA  = bus.fwd_a_e;
    capFwdB  = bus.fwd_b_e;
    @(posedge clk);
    if (mW.v) expRet = expRet + 1'b1;
    mW = mM;
    mM = mE;
    mE = (fl || expStall || !d.v) ? NOP : d;
    @(negedge clk);
    checkRegs();
  endtask

  initial begin
    logic st;
    ins_t cur;
    logic fl;

    rst_n = 1'b0;
    bus.valid_d = 0; bus.reg_write_d = 0; bus.result_src_d = 0; bus.mem_write_d = 0;
    bus.alu_src_d = 0; bus.alu_op_d = 0; bus.rd_d = 0; bus.rs1_d = 0; bus.rs2_d = 0;
    bus.rs1_e = 0; bus.rs2_e = 0; bus.flush_e = 0;
    modelReset();
    #3;
    checkAllZero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // add x5 ; sub x6,x5 ; or x7,x5 ; nop -> M forward then W forward
    step(mk(1, 1, 0, 0, 0, 2'b10, 5, 1, 2), 0, st);
    step(mk(1, 1, 0, 0, 0, 2'b10, 6, 5, 3), 0, st);
    step(mk(1, 1, 0, 0, 0, 2'b10, 7, 5, 4), 0, st);
    chk("t2_fwd_m", 32'(capFwdA), 32'h2);
    chk("t2_nostall_m", 32'(capStall), 0);
    step(NOP, 0, st);
    chk("t2_fwd_w", 32'(capFwdA), 32'h1);
    chk("t2_nostall_w", 32'(capStall), 0);

    // lw x7 ; add rs2=x7 -> one stall cycle, bubble, then W forward
    step(mk(1, 1, 1, 0, 1, 2'b00, 7, 1, 0), 0, st);
    step(mk(1, 1, 0, 0, 0, 2'b10, 8, 2, 7), 0, st);
    chk("t3_stall", 32'(capStall), 1);
    chk("t3_bubble_rw", 32'(bus.reg_write_e), 0);
    chk("t3_bubble_rd", 32'(bus.rd_e), 0);
    step(mk(1, 1, 0, 0, 0, 2'b10, 8, 2, 7), 0, st);
    chk("t3_stall_once", 32'(capStall), 0);
    step(NOP, 0, st);
    chk("t3_fwd_b_w", 32'(capFwdB), 32'h1);

    // lw x0 ; use x0 -> no stall, no forward
    step(mk(1, 1, 1, 0, 1, 2'b00, 0, 1, 0), 0, st);
    step(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 0), 0, st);
    chk("t4_nostall_x0", 32'(capStall), 0);
    step(NOP, 0, st);
    chk("t4_nofwd_a_x0", 32'(capFwdA), 0);
    chk("t4_nofwd_b_x0", 32'(capFwdB), 0);
    step(NOP, 0, st);
    step(NOP, 0, st);
    step(NOP, 0, st);

    // store squashed by flush never reaches M and never retires
    begin
      logic [CNT_W-1:0] retBefore;
      retBefore = bus.retired;
      step(mk(1, 0, 0, 1, 1, 2'b00, 0, 3, 4), 1, st);
      step(NOP, 0, st);
      chk("t5_mem_write_m", 32'(bus.mem_write_m), 0);
      step(NOP, 0, st);
      step(NOP, 0, st);
      chk("t5_no_retire", 32'(bus.retired), 32'(retBefore));
    end

    // random traffic; stalled instruction is re-presented next cycle
    cur = NOP;
    st  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!st) begin
        cur = mk(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 2'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end
      fl = ($urandom % 8) == 0;
      step(cur, fl, st);
    end

    // asynchronous reset mid-stream with instructions in flight
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 0, 0, 0, 2'b01, 5'(i + 1), 0, 0), 0, st);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    @(negedge clk);
    checkAllZero("rst_held");
    rst_n = 1'b1;
    modelReset();
    step(NOP, 0, st);
    chk("rst_retired_zero", 32'(bus.retired), 0);

    // 17 back-to-back retirements on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      step(mk(1, 0, 0, 0, 1, 2'b00, 5'(i % 4), 0, 0), 0, st);
      if (i == 16) chk("t6_wrapped", 32'(bus.retired), 32'hE);
    end
    for (int i = 0; i < 3; i++) step(NOP, 0, st);
    chk("t6_retired_end", 32'(bus.retired), 32'h1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
